seg_rca_adder: RTL and testbench

Parametrised, clocked ripple-carry adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock. It uses a start/done handshake and holds the result until the next operation. It is the sequential, width-generic successor to the 4-bit combinational ripple adder and sits between the datapath operand registers and any consumer that needs wide sums without a long combinational carry chain.

---
 rtl/seg_rca_pkg.sv | 16 +
 rtl/rca_chunk.sv | 26 ++
 rtl/seg_rca_adder.sv | 145 ++++++++++++++
 tb/tb_seg_rca_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_rca_pkg.sv
// Shared constants for the segmented ripple-carry adder/subtractor.
package seg_rca_pkg;

    localparam int unsigned SEG_RCA_WIDTH = 32;
    localparam int unsigned SEG_RCA_CHUNK = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Index width for n chunks; never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder, one full adder per bit.
module rca_chunk #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    // Full-adder chain: carry ripples from bit 0 upward.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[W];
    end

endmodule

// File: rtl/seg_rca_adder.sv
// Sequential WIDTH-bit adder/subtractor computing CHUNK bits per clock with a
// single time-multiplexed ripple chunk. Define SEG_RCA_OVF_EN to produce the
// signed-overflow flag; otherwise ovf is held at 0.
module seg_rca_adder
    import seg_rca_pkg::*;
#(
    parameter int unsigned WIDTH = SEG_RCA_WIDTH,
    parameter int unsigned CHUNK = SEG_RCA_CHUNK
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = clog2_min1(NCHUNK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;     // effective B (already inverted for subtract)
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SEG_RCA_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    int unsigned      shamt;
    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
    logic             chunk_co;

    // Select the active chunk of the captured operands.
    assign shamt   = 32'(idx_q) * CHUNK;
    assign chunk_a = CHUNK'(a_q >> shamt);
    assign chunk_b = CHUNK'(b_q >> shamt);

    rca_chunk #(.W(CHUNK)) u_chunk (
        .a  (chunk_a),
        .b  (chunk_b),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // Next-state: accept in IDLE/DONE, one chunk per RUN cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;
`ifdef SEG_RCA_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = op ? ~b : b;
                    carry_d = op ? 1'b1 : ci;
                    idx_d   = '0;
                    s_d     = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                s_d     = s_q | (WIDTH'(chunk_s) << shamt);
                carry_d = chunk_co;
                if (idx_q == IDX_LAST) begin
                    co_d    = chunk_co;
`ifdef SEG_RCA_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (s_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEG_RCA_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEG_RCA_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
`ifdef SEG_RCA_OVF_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_seg_rca_adder.sv
// Scoreboard bench for seg_rca_adder (32/4 instance plus a 4/4 single-chunk one).
module tb_seg_rca_adder;

    localparam int unsigned W = 32;
    localparam int unsigned C = 4;
    localparam int unsigned N = W / C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start, op, ci;
    logic [W-1:0]  a, b;
    logic          busy, done, co, ovf;
    logic [W-1:0]  s;

    logic          start4, op4, ci4;
    logic [3:0]    a4, b4;
    logic          busy4, done4, co4, ovf4;
    logic [3:0]    s4;

    seg_rca_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
    );

    seg_rca_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .op(op4), .a(a4), .b(b4), .ci(ci4),
        .busy(busy4), .done(done4), .s(s4), .co(co4), .ovf(ovf4)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        int           due;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference arithmetic on plain integers, w-bit wide.
    task automatic ref_op(input int unsigned w, input longint unsigned aa, input longint unsigned bb,
                          input logic o, input logic c,
                          output longint unsigned rs, output logic rco, output logic rovf);
        longint unsigned m, full;
        longint signed   lim, sa, sb, sr;
        m   = (longint'(1) << w) - 1;
        lim = longint'(1) << (w - 1);
        sa  = (aa >= longint'(lim)) ? longint'(aa) - 2 * lim : longint'(aa);
        sb  = (bb >= longint'(lim)) ? longint'(bb) - 2 * lim : longint'(bb);
        if (!o) begin
            full = aa + bb + longint'(c);
            rs   = full & m;
            rco  = ((full >> w) & 1) != 0;
            sr   = sa + sb + longint'(c);
        end else begin
            rs   = (aa - bb) & m;
            rco  = (aa >= bb);
            sr   = sa - sb;
        end
`ifdef SEG_RCA_OVF_EN
        rovf = (sr >= lim) || (sr < -lim);
`else
        rovf = 1'b0;
`endif
    endtask

    // Monitor: pop on every done pulse; otherwise idle outputs must hold.
    logic [W-1:0] held_s;
    logic         held_co, held_ovf;
    bit           held_v = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            held_s = '0; held_co = 1'b0; held_ovf = 1'b0; held_v = 1;
        end else if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                e = exp_q.pop_front();
                chk("result_s", 64'(s), 64'(e.s));
                chk("result_co", 64'(co), 64'(e.co));
                chk("result_ovf", 64'(ovf), 64'(e.ovf));
                chk("done_cycle", 64'(cyc), 64'(e.due));
                held_s = e.s; held_co = e.co; held_ovf = e.ovf; held_v = 1;
            end
        end else if (busy === 1'b0 && held_v) begin
            chk("hold_s", 64'(s), 64'(held_s));
            chk("hold_co_ovf", 64'({co, ovf}), 64'({held_co, held_ovf}));
        end
    end

    // Issue one operation at a negedge; returns at the negedge after acceptance.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic to, input logic tc);
        int guard;
        exp_t e;
        longint unsigned rs;
        logic rco, rovf;
        guard = 0;
        while (busy !== 1'b0) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                checks++; errors++;
                $display("FAIL busy_timeout: got busy=%b expected 0 within 200 cycles", busy);
                return;
            end
        end
        ref_op(W, longint'(ta), longint'(tb), to, tc, rs, rco, rovf);
        e.s = W'(rs); e.co = rco; e.ovf = rovf; e.due = cyc + 1 + int'(N);
        exp_q.push_back(e);
        a = ta; b = tb; op = to; ci = tc; start = 1'b1;
        @(negedge clk);
        chk("busy_after_accept", 64'(busy), 64'(1));
        start = 1'b0;
        a = $urandom; b = $urandom; op = 1'($urandom); ci = 1'($urandom);
    endtask

    // Single-chunk instance: done must follow the edge after acceptance.
    task automatic op4_run(input logic [3:0] ta, input logic [3:0] tb, input logic tc, input logic [4:0] req);
        a4 = ta; b4 = tb; ci4 = tc; op4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("w4_busy", 64'({busy4, done4}), 64'(2'b10));
        @(negedge clk);
        chk("w4_done", 64'({busy4, done4}), 64'(2'b01));
        chk("w4_sum", 64'({co4, s4}), 64'(req));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = '1;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int bc, guard;
        reset_n = 1'b0;
        start = 0; op = 0; ci = 0; a = '0; b = '0;
        start4 = 0; op4 = 0; ci4 = 0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("reset_flags", 64'({busy, done, co, ovf}), 64'(0));
        chk("reset_s", 64'(s), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        op4_run(4'h0, 4'h0, 1'b0, 5'h00);
        op4_run(4'h5, 4'h4, 1'b0, 5'h09);
        op4_run(4'hF, 4'hF, 1'b1, 5'h1F);

        // Full carry ripple and busy duration.
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        bc = 1;
        while (busy === 1'b1 && bc < 50) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
        end
        chk("busy_cycles", 64'(bc), 64'(N));

        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);

        // Start pulses during RUN must be ignored.
        do_op(32'h0000_1234, 32'h0000_0F0F, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 60; i++) begin
            do_op(pick(), pick(), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Asynchronous reset at idx=3 discards the operation.
        do_op(32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_reset_flags", 64'({busy, done, co, ovf}), 64'(0));
        chk("async_reset_s", 64'(s), 64'(0));
        void'(exp_q.pop_back());
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
